// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared types and constants for the bit-serial arithmetic
//               blocks (state encoding, default operand width).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

    // Default operand/result width for serial arithmetic units
    localparam int C_DEFAULT_WIDTH = 4;

    // Controller states: waiting for a request, or shifting bits through the cell
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit combinational full subtractor: d = a - b - bin,
//               with borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic w_a_xor_b;

    assign w_a_xor_b = a_i ^ b_i;
    assign d_o       = w_a_xor_b ^ bin_i;
    // Borrow when b exceeds a, or when a==b and a borrow is already pending
    assign bout_o    = (~a_i & b_i) | (~w_a_xor_b & bin_i);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial ripple-borrow subtractor. Computes
//               D = A - B - B_in over N bits, LSB first, one bit per clock,
//               through a single reused full-subtractor cell. Operands are
//               captured on an accepted start; done pulses for one cycle
//               when D and B_out are updated.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int N = C_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         B_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         B_out
);

    // Counter must reach N-1; $clog2(N) bits suffice for N >= 2
    localparam int              CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t             state_q;
    logic [N-1:0]       a_sh_q;
    logic [N-1:0]       b_sh_q;
    logic [N-1:0]       d_sh_q;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [N-1:0]       d_q;
    logic               b_out_q;

    logic               w_cell_d;
    logic               w_cell_bout;
    logic [N-1:0]       d_sh_d;

    // The single shared cell consumes the current LSBs and the running borrow
    full_subtractor u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (borrow_q),
        .d_o    (w_cell_d),
        .bout_o (w_cell_bout)
    );

    // Difference bits enter at the MSB so the first (LSB) result ends at bit 0
    assign d_sh_d = {w_cell_d, d_sh_q[N-1:1]};

    // Controller, datapath shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            b_out_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q   <= A;
                        b_sh_q   <= B;
                        borrow_q <= B_in;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    d_sh_q   <= d_sh_d;
                    borrow_q <= w_cell_bout;
                    cnt_q    <= cnt_q + C_CNT_ONE;
                    // Last bit: publish the full result including this cycle's bit
                    if (cnt_q == C_LAST) begin
                        d_q     <= d_sh_d;
                        b_out_q <= w_cell_bout;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign D     = d_q;
    assign B_out = b_out_q;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor at N=4
//               and N=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] A4 = '0, B4 = '0;
    logic       Bin4 = 1'b0;
    logic       busy4, done4, Bout4;
    logic [3:0] D4;

    logic       start8 = 1'b0;
    logic [7:0] A8 = '0, B8 = '0;
    logic       Bin8 = 1'b0;
    logic       busy8, done8, Bout8;
    logic [7:0] D8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(A4), .B(B4), .B_in(Bin4),
        .busy(busy4), .done(done4), .D(D4), .B_out(Bout4)
    );

    serial_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8), .B_in(Bin8),
        .busy(busy8), .done(done8), .D(D8), .B_out(Bout8)
    );

    // Issue one N=4 request and wait (bounded) for done; all sampling on negedge.
    // lat counts edges after the accepting edge until done is seen.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       output logic [3:0] d, output logic bo, output int lat,
                       output int busy_cnt, output logic d_stable);
        logic [3:0] d_before;
        @(negedge clk);
        d_before = D4;
        A4 = a; B4 = b; Bin4 = bin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0; busy_cnt = 0; d_stable = 1'b1;
        while (!done4 && lat < 40) begin
            if (busy4) busy_cnt++;
            if (D4 !== d_before) d_stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        d = D4; bo = Bout4;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output int lat);
        @(negedge clk);
        A8 = a; B8 = b; Bin8 = bin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        d = D8; bo = Bout8;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy4, done4, D4, Bout4} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_n4: busy=%b done=%b D=%0d B_out=%b, required all zero", busy4, done4, D4, Bout4);
        end
        n_vec++;
        if ({busy8, done8, D8, Bout8} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_n8: busy=%b done=%b D=%0d B_out=%b, required all zero", busy8, done8, D8, Bout8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic [3:0] va [6] = '{4'd12, 4'd3,  4'd13, 4'd15, 4'd0, 4'd8};
        logic [3:0] vb [6] = '{4'd10, 4'd11, 4'd10, 4'd15, 4'd0, 4'd8};
        logic       vi [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0, 1'b1};
        logic [3:0] ed [6] = '{4'd1,  4'd8,  4'd2,  4'd15, 4'd0, 4'd15};
        logic       eb [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0, 1'b1};
        logic [3:0] d; logic bo, st; int lat, bc;
        for (int i = 0; i < 6; i++) begin
            op4(va[i], vb[i], vi[i], d, bo, lat, bc, st);
            n_vec++;
            if (d !== ed[i] || bo !== eb[i]) begin
                n_err++;
                $display("FAIL vector %0d (%0d-%0d-%0d): D=%0d B_out=%b, required D=%0d B_out=%b",
                         i, va[i], vb[i], vi[i], d, bo, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_latency;
        logic [3:0] d; logic bo, st; int lat, bc;
        op4(4'd7, 4'd2, 1'b0, d, bo, lat, bc, st);
        n_vec++;
        if (lat !== 4) begin
            n_err++; $display("FAIL latency_done: edges=%0d, required 4", lat);
        end
        n_vec++;
        if (bc !== 4) begin
            n_err++; $display("FAIL latency_busy: busy cycles=%0d, required 4", bc);
        end
        n_vec++;
        if (st !== 1'b1) begin
            n_err++; $display("FAIL latency_d_hold: D changed before done, required stable");
        end
        n_vec++;
        if (d !== 4'd5 || bo !== 1'b0) begin
            n_err++; $display("FAIL latency_result: D=%0d B_out=%b, required D=5 B_out=0", d, bo);
        end
        // done must drop after one cycle
        @(negedge clk);
        n_vec++;
        if (done4 !== 1'b0) begin
            n_err++; $display("FAIL done_width: done=%b one cycle later, required 0", done4);
        end
    endtask

    task automatic test_ignored_start;
        int lat = 0; int extra = 0;
        @(negedge clk);
        A4 = 4'd12; B4 = 4'd10; Bin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        A4 = 4'd1; B4 = 4'd0; Bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 2;
        while (!done4 && lat < 40) begin @(negedge clk); lat++; end
        n_vec++;
        if (D4 !== 4'd1 || Bout4 !== 1'b0 || lat !== 4) begin
            n_err++;
            $display("FAIL ignored_start: D=%0d B_out=%b edges=%0d, required D=1 B_out=0 edges=4", D4, Bout4, lat);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++; $display("FAIL ignored_no_second: %0d cycles with done/busy, required 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        @(negedge clk);
        A4 = 4'd5; B4 = 4'd2; Bin4 = 1'b0; start4 = 1'b1;
        gap = 0;
        while (!done4 && gap < 40) begin @(negedge clk); gap++; end
        for (int r = 0; r < 3; r++) begin
            n_vec++;
            if (done4 !== 1'b1 || D4 !== 4'd3 || Bout4 !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_result %0d: done=%b D=%0d B_out=%b, required done=1 D=3 B_out=0", r, done4, D4, Bout4);
            end
            @(negedge clk);
            gap = 1;
            while (!done4 && gap < 40) begin @(negedge clk); gap++; end
            n_vec++;
            if (gap !== 5) begin
                n_err++; $display("FAIL b2b_period %0d: period=%0d, required 5", r, gap);
            end
        end
        start4 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        logic [3:0] d; logic bo, st; int lat, bc; int seen_done = 0;
        op4(4'd12, 4'd10, 1'b1, d, bo, lat, bc, st);  // leaves D=1 behind
        @(negedge clk);
        A4 = 4'd3; B4 = 4'd10; Bin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4) seen_done++;
        end
        n_vec++;
        if (busy4 !== 1'b0 || D4 !== 4'd0 || Bout4 !== 1'b0 || seen_done !== 0) begin
            n_err++;
            $display("FAIL reset_midrun: busy=%b D=%0d B_out=%b dones=%0d, required 0 0 0 0", busy4, D4, Bout4, seen_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        op4(4'd3, 4'd10, 1'b1, d, bo, lat, bc, st);
        n_vec++;
        if (d !== 4'd8 || bo !== 1'b1 || lat !== 4) begin
            n_err++;
            $display("FAIL reset_rerun: D=%0d B_out=%b edges=%0d, required D=8 B_out=1 edges=4", d, bo, lat);
        end
        @(negedge clk);
        n_vec++;
        if (done4 !== 1'b0) begin
            n_err++; $display("FAIL reset_rerun_done_width: done=%b, required 0", done4);
        end
    endtask

    task automatic test_exhaustive4;
        logic [3:0] d; logic bo, st; int lat, bc;
        logic [4:0] ref5;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    op4(4'(a), 4'(b), 1'(bi), d, bo, lat, bc, st);
                    ref5 = 5'(a) - 5'(b) - 5'(bi);
                    n_vec++;
                    if (d !== ref5[3:0] || bo !== (a < b + bi) || lat !== 4) begin
                        n_err++;
                        $display("FAIL exh4 %0d-%0d-%0d: D=%0d B_out=%b edges=%0d, required D=%0d B_out=%b edges=4",
                                 a, b, bi, d, bo, lat, ref5[3:0], (a < b + bi));
                    end
                end
    endtask

    task automatic test_width8;
        logic [7:0] d, a, b; logic bo, bi; int lat;
        logic [8:0] ref9;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            bi = 1'($urandom_range(0, 1));
            op8(a, b, bi, d, bo, lat);
            ref9 = {1'b0, a} - {1'b0, b} - 9'(bi);
            n_vec++;
            if (d !== ref9[7:0] || bo !== ref9[8] || lat !== 8) begin
                n_err++;
                $display("FAIL n8 %0d-%0d-%0d: D=%0d B_out=%b edges=%0d, required D=%0d B_out=%b edges=8",
                         a, b, bi, d, bo, lat, ref9[7:0], ref9[8]);
            end
        end
        op8(8'd0, 8'd255, 1'b1, d, bo, lat);
        n_vec++;
        if (d !== 8'd0 || bo !== 1'b1 || lat !== 8) begin
            n_err++;
            $display("FAIL n8_corner: D=%0d B_out=%b edges=%0d, required D=0 B_out=1 edges=8", d, bo, lat);
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_latency;
        test_ignored_start;
        test_back_to_back;
        test_reset_midrun;
        test_exhaustive4;
        test_width8;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: computes D = A - B - B_in over N bits, LSB first, one bit per clock.
- Complements the combinational ripple-carry adder: subtraction instead of addition, and N cycles through one reused cell instead of N cells in a chain.
- Used where area matters more than latency. Operand transfer uses a start/busy/done handshake.

Parameters:
- N, 4, operand/result width in bits (N >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  N  minuend, captured on accepted start
- B  input  N  subtrahend, captured on accepted start
- B_in  input  1  borrow-in, captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when D and B_out are updated
- D  output  N  difference, modulo 2^N
- B_out  output  1  final borrow; 1 iff A < B + B_in (unsigned)

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n.
  - While rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, D=0, B_out=0; internal shift registers, borrow flop and bit counter are cleared.
- States: IDLE, BUSY.
- IDLE:
  - start=1 at an edge: capture A, B and B_in; borrow flop <= B_in; count <= 0; state <= BUSY; busy <= 1.
  - start=0: hold.
- BUSY, each edge:
  - Feed a=A_sh[0], b=B_sh[0], bin=borrow to the cell.
  - Shift A_sh and B_sh right by one.
  - Shift the cell difference into D_sh at the MSB.
  - borrow <= cell bout; count <= count+1.
- Completion, on the edge that processes bit N-1 (the Nth BUSY edge):
  - D <= final D_sh, including that bit.
  - B_out <= final bout.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge k gives done=1 and valid D/B_out after edge k+N. done is high for exactly one cycle. The next accepted start is at edge k+N+1 at the earliest.
- Back-to-back: start=1 while done=1 is accepted (state is IDLE). Throughput is one result per N+1 cycles.
- start while busy=1 is ignored; no queuing. Changes to A/B/B_in after capture have no effect.
- D and B_out hold their last value until the next completion. They do not change during BUSY.
- Reset mid-operation aborts the subtraction: no done pulse, and outputs clear as above.
- Arithmetic: D = (A - B - B_in) mod 2^N and B_out = (A < B + B_in). Computed as an (N+1)-bit compare with no overflow. A=B=2^N-1 with B_in=1 gives D=2^N-1, B_out=1.
- Counter width: $clog2(N) bits, and it must count up to N-1 without wrapping early.

Decomposition:
- Shared package (serial_arith_pkg):
  - state encoding IDLE/BUSY as a 1-bit enum/localparam
  - default width constant (4)
- Sub-module full_subtractor, purely combinational:
  - d = a ^ b ^ bin
  - bout = (~a & b) | (~(a ^ b) & bin)
- Instantiate full_subtractor once.

Test Plan:
- Reset mid-run: start A=3, B=10, B_in=1; assert rst_n=0 after two BUSY edges -> busy=0, done never pulses, D=0, B_out=0. Release reset, repeat the request -> after N=4 edges D=8, B_out=1, done high one cycle.
- Sequential vectors, N=4 (A, B, B_in -> D, B_out):
  - 12, 10, 1 -> 1, 0
  - 3, 11, 0 -> 8, 1
  - 13, 10, 1 -> 2, 0
  - 15, 15, 1 -> 15, 1
  - 0, 0, 0 -> 0, 0
  - 8, 8, 1 -> 15, 1
- Latency: check done asserts exactly 4 edges after start is sampled, busy is high for exactly those 4 cycles, and D is unchanged until done.
- Ignored start: pulse start with A=1, B=0 during BUSY of a 12-10-1 run -> result D=1, B_out=0, and no second done follows.
- Back-to-back: hold start=1 continuously with A=5, B=2, B_in=0 -> done every 5 cycles, D=3, B_out=0 each time.
- Exhaustive, N=4: all 512 (A, B, B_in) combinations against the reference model; then N=8 with random vectors, done at 8 edges, plus A=0, B=255, B_in=1 -> D=0, B_out=1.
